// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types for the UART transmit arbiter: FSM state encoding,
// the requester ceiling and a one-hot to index encoder.
package uart_arb_pkg;

    localparam int MAX_REQ   = 8;
    localparam int MAX_IDX_W = $clog2(MAX_REQ);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SEND  = 3'd1,
        ACK   = 3'd2,
        DRAIN = 3'd3,
        HOLD  = 3'd4
    } arb_state_t;

    // OR-reduction encoder; the input is one-hot or all zero.
    function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        logic [MAX_IDX_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) r = r | MAX_IDX_W'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Bundle between the message sources, the arbiter and the shared uart_tx.
// Handshake: requester i raises req_valid[i] with req_data/req_last and holds
// them unchanged until the cycle req_ready[i] is high; a byte is transferred on
// req_valid[i] & req_ready[i]. tx_start is a one-cycle pulse, tx_busy the
// transmitter's reply.
interface uart_tx_arbiter_if #(parameter int N_REQ = 4);

    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_last;
    logic [N_REQ-1:0]   req_ready;
    logic               tx_start;
    logic [7:0]         tx_data;
    logic               tx_busy;
    logic [N_REQ-1:0]   grant;
    logic               busy;
    logic               timeout;

    modport master (
        input  req_valid, req_data, req_last, tx_busy,
        output req_ready, tx_start, tx_data, grant, busy, timeout
    );

    modport slave (
        output req_valid, req_data, req_last, tx_busy,
        input  req_ready, tx_start, tx_data, grant, busy, timeout
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin picker: one-hot first set bit of req at or after
// ptr, wrapping at N-1 so non-power-of-two widths behave.
module rr_picker #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         pick,
    output logic                 found
);

    localparam int PW = $clog2(N);

    logic [PW-1:0] idx;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = ptr;
        for (int k = 0; k < N; k++) begin
            if (!found && req[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
            idx = (idx == PW'(N - 1)) ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-locked scheduler sharing one uart_tx among N_REQ byte
// streams; a grant lasts until a last byte or HOLD_TIMEOUT idle cycles.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int HOLD_TIMEOUT = 65535
) (
    input  logic                     clk,
    input  logic                     rst,
    uart_tx_arbiter_if.master        bus,
    output arb_state_t               dbg_state,
    output logic [$clog2(N_REQ)-1:0] dbg_rr_ptr
);

    localparam int PW = $clog2(N_REQ);
    localparam int CW = (HOLD_TIMEOUT > 1) ? $clog2(HOLD_TIMEOUT) : 1;

    arb_state_t       state;
    logic [N_REQ-1:0] grant_q;
    logic [PW-1:0]    g_idx;
    logic [PW-1:0]    rr_ptr;
    logic [7:0]       data_q;
    logic             last_q;
    logic [CW-1:0]    hold_cnt;
    logic             timeout_q;

    logic [N_REQ-1:0] pick;
    logic             found;
    logic [PW-1:0]    pick_idx;
    logic [7:0]       pick_data;
    logic             pick_last;
    logic             owner_valid;
    logic [7:0]       owner_data;
    logic             owner_last;
    logic [PW-1:0]    next_ptr;

    rr_picker #(.N(N_REQ)) u_picker (
        .req   (bus.req_valid),
        .ptr   (rr_ptr),
        .pick  (pick),
        .found (found)
    );

    assign pick_idx    = PW'(onehot_to_idx(MAX_REQ'(pick)));
    assign pick_data   = bus.req_data[8*int'(pick_idx) +: 8];
    assign pick_last   = bus.req_last[pick_idx];
    assign owner_valid = bus.req_valid[g_idx];
    assign owner_data  = bus.req_data[8*int'(g_idx) +: 8];
    assign owner_last  = bus.req_last[g_idx];
    // Explicit wrap compare so N_REQ need not be a power of two.
    assign next_ptr    = (g_idx == PW'(N_REQ - 1)) ? '0 : g_idx + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            grant_q   <= '0;
            g_idx     <= '0;
            rr_ptr    <= '0;
            data_q    <= 8'h00;
            last_q    <= 1'b0;
            hold_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        grant_q <= pick;
                        g_idx   <= pick_idx;
                        data_q  <= pick_data;
                        last_q  <= pick_last;
                        state   <= SEND;
                    end
                end
                SEND: state <= ACK;
                ACK: begin
                    if (bus.tx_busy) state <= DRAIN;
                end
                DRAIN: begin
                    if (!bus.tx_busy) begin
                        if (last_q) begin
                            grant_q <= '0;
                            rr_ptr  <= next_ptr;
                            state   <= IDLE;
                        end else if (owner_valid) begin
                            data_q <= owner_data;
                            last_q <= owner_last;
                            state  <= SEND;
                        end else begin
                            hold_cnt <= '0;
                            state    <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    // A byte arriving on the expiry cycle still wins.
                    if (owner_valid) begin
                        data_q <= owner_data;
                        last_q <= owner_last;
                        state  <= SEND;
                    end else if (hold_cnt == CW'(HOLD_TIMEOUT - 1)) begin
                        grant_q   <= '0;
                        rr_ptr    <= next_ptr;
                        timeout_q <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.tx_start  = (state == SEND);
    assign bus.req_ready = (state == SEND) ? grant_q : '0;
    assign bus.tx_data   = data_q;
    assign bus.grant     = grant_q;
    assign bus.busy      = |grant_q;
    assign bus.timeout   = timeout_q;
    assign dbg_state     = state;
    assign dbg_rr_ptr    = rr_ptr;

endmodule
